// File: rtl/acc_rd_scoreboard.sv
// Hazard tracker for accelerator writebacks: counts in-flight writes per GPR
// and drives the offload request's rs_valid / rd_clean fields from that state.
module acc_rd_scoreboard #(
  parameter int unsigned NumRegs   = 32,
  parameter bit          InOrderWb = 1'b0,
  parameter int unsigned MaxPerReg = 3,
  parameter int unsigned MaxTotal  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_data_i,
  input  logic        q_valid_i,
  input  logic        q_ready_i,
  input  logic        k_accept_i,
  input  logic [1:0]  k_writeback_i,
  output logic [2:0]  rs_valid_o,
  output logic [1:0]  rd_clean_o,
  input  logic        p_valid_i,
  input  logic        p_ready_i,
  input  logic [4:0]  p_rd_i,
  input  logic        p_dual_writeback_i,
  output logic        busy_o,
  output logic        full_o,
  output logic        err_o
);

  localparam int unsigned CntW = (MaxPerReg + 1 > 1) ? $clog2(MaxPerReg + 1) : 1;
  localparam int unsigned TotW = (MaxTotal + 1 > 1) ? $clog2(MaxTotal + 1) : 1;

  logic [CntW-1:0] pend_q [NumRegs];
  logic [CntW-1:0] pend_d [NumRegs];
  logic [TotW-1:0] tot_q, tot_d;
  logic            err_q, err_d;

  logic [4:0] rd, rdd, rs1, rs2, rs3, p_rdd;
  logic       iss, ret;
  logic       unused_instr;

  assign rd    = instr_data_i[11:7];
  assign rs1   = instr_data_i[19:15];
  assign rs2   = instr_data_i[24:20];
  assign rs3   = instr_data_i[31:27];
  assign rdd   = {rd[4:1], 1'b1};
  assign p_rdd = {p_rd_i[4:1], 1'b1};
  assign unused_instr = ^{instr_data_i[26:25], instr_data_i[14:12], instr_data_i[6:0]};

  assign iss = q_valid_i & q_ready_i & k_accept_i;
  assign ret = p_valid_i & p_ready_i;

  // Issue and retire hitting the same register net out before saturation, so
  // their relative order within a cycle never matters.
  always_comb begin
    int inc_r, dec_r, nxt, inc_total, dec_total, tot_nxt;
    err_d     = err_q;
    inc_total = 0;
    dec_total = 0;
    inc_r     = 0;
    dec_r     = 0;
    nxt       = 0;
    pend_d[0] = '0;
    for (int r = 1; r < NumRegs; r++) begin
      inc_r = 0;
      dec_r = 0;
      if (iss && k_writeback_i[0] && (rd == 5'(r))) inc_r = inc_r + 1;
      if (iss && k_writeback_i[1] && (rdd == 5'(r))) inc_r = inc_r + 1;
      if (ret && (p_rd_i == 5'(r))) dec_r = dec_r + 1;
      if (ret && p_dual_writeback_i && (p_rdd == 5'(r))) dec_r = dec_r + 1;
      nxt = int'(pend_q[r]) + inc_r - dec_r;
      if (nxt < 0) begin
        nxt   = 0;
        err_d = 1'b1;
      end else if (nxt > int'(MaxPerReg)) begin
        nxt   = int'(MaxPerReg);
        err_d = 1'b1;
      end
      pend_d[r] = CntW'(nxt);
      inc_total = inc_total + inc_r;
      dec_total = dec_total + dec_r;
    end
    // A dual writeback must name an even rd.
    if (iss && k_writeback_i[1] && rd[0]) err_d = 1'b1;
    tot_nxt = int'(tot_q) + inc_total - dec_total;
    if (tot_nxt < 0) begin
      tot_nxt = 0;
      err_d   = 1'b1;
    end else if (tot_nxt > int'(MaxTotal)) begin
      tot_nxt = int'(MaxTotal);
      err_d   = 1'b1;
    end
    tot_d = TotW'(tot_nxt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NumRegs; r++) pend_q[r] <= '0;
      tot_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NumRegs; r++) pend_q[r] <= pend_d[r];
      tot_q <= tot_d;
      err_q <= err_d;
    end
  end

  // Outputs look only at registered state and the instruction word, keeping
  // the adapter's q_ready and the P channel off every output path.
  logic [CntW-1:0] cnt_rs1, cnt_rs2, cnt_rs3, cnt_rd, cnt_rdd;
  logic            room;

  always_comb begin
    cnt_rs1 = '0;
    cnt_rs2 = '0;
    cnt_rs3 = '0;
    cnt_rd  = '0;
    cnt_rdd = '0;
    for (int r = 1; r < NumRegs; r++) begin
      if (rs1 == 5'(r)) cnt_rs1 = pend_q[r];
      if (rs2 == 5'(r)) cnt_rs2 = pend_q[r];
      if (rs3 == 5'(r)) cnt_rs3 = pend_q[r];
      if (rd  == 5'(r)) cnt_rd  = pend_q[r];
      if (rdd == 5'(r)) cnt_rdd = pend_q[r];
    end
  end

  function automatic logic target_ok(input logic [CntW-1:0] cnt);
    if (InOrderWb) return int'(cnt) < int'(MaxPerReg);
    return cnt == '0;
  endfunction

  assign room = (int'(tot_q) + 2) <= int'(MaxTotal);

  assign rs_valid_o[0] = (rs1 == 5'd0) | (cnt_rs1 == '0);
  assign rs_valid_o[1] = (rs2 == 5'd0) | (cnt_rs2 == '0);
  assign rs_valid_o[2] = (rs3 == 5'd0) | (cnt_rs3 == '0);
  assign rd_clean_o[0] = room & ((rd == 5'd0) | target_ok(cnt_rd));
  assign rd_clean_o[1] = room & target_ok(cnt_rdd);

  assign busy_o = (tot_q != '0);
  assign full_o = (tot_q == TotW'(MaxTotal));
  assign err_o  = err_q;

  // Once a protocol error is flagged the counters are no longer trustworthy,
  // so the sum invariant is only expected to hold before that.
  int pend_sum;
  always_comb begin
    pend_sum = 0;
    for (int r = 0; r < NumRegs; r++) pend_sum = pend_sum + int'(pend_q[r]);
  end

  a_clean_rd: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (iss && k_writeback_i[0]) |-> rd_clean_o[0]);
  a_clean_rdd: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (iss && k_writeback_i[1]) |-> rd_clean_o[1]);
  a_tot_sum: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !err_q |-> (int'(tot_q) == pend_sum));

endmodule

// File: doc/acc_rd_scoreboard.md
Name: acc_rd_scoreboard

Overview:
- Core-side hazard tracker directly upstream of the X-interface offload adapter. It generates the `q.rs_valid` and `q.rd_clean` request fields.
- Counts in-flight accelerator writebacks per GPR. Increments on accepted offloads and decrements on P-channel (response) writebacks.
- Stalls RAW/WAW hazards against accelerator results that are still outstanding.
- Also enforces a global cap on outstanding writebacks.

Parameters:
- NumRegs, 32, number of architectural GPRs tracked (x0 never tracked).
- InOrderWb, 0, 1: accelerator writebacks return in issue order, so WAW allowed up to MaxPerReg; 0: rd_clean only when no write is pending.
- MaxPerReg, 3, per-register pending counter saturation value (counter width = idx_width(MaxPerReg+1)).
- MaxTotal, 8, max total pending register writes across all GPRs.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_data_i  in  32  offloaded instruction (same word as X-request `q.instr_data`)
- q_valid_i  in  1  X-request valid
- q_ready_i  in  1  X-response q_ready from adapter
- k_accept_i  in  1  X-response `k.accept`
- k_writeback_i  in  2  X-response `k.writeback`; bit0 = rd, bit1 = rd|1 (dual)
- rs_valid_o  out  3  to X-request `q.rs_valid` (rs1, rs2, rs3)
- rd_clean_o  out  2  to X-request `q.rd_clean` (rd, rd|1)
- p_valid_i  in  1  X-response p_valid
- p_ready_i  in  1  X-request p_ready
- p_rd_i  in  5  X-response `p.rd`
- p_dual_writeback_i  in  1  X-response `p.dual_writeback`
- busy_o  out  1  any register write pending
- full_o  out  1  total pending == MaxTotal
- err_o  out  1  sticky protocol-error flag

Behaviour:
- Register fields:
  - rd = instr[11:7], rs1 = [19:15], rs2 = [24:20], rs3 = [31:27].
  - Dual destination rdd = {rd[4:1], 1'b1}.
- State: pend[NumRegs] counters, tot counter, err flag.
  - Async reset clears all state.
  - Reset values: rs_valid_o = 3'b111, rd_clean_o = 2'b11, busy_o = 0, full_o = 0, err_o = 0.
  - Reset mid-operation drops all tracking; no draining.
- Issue event: `iss = q_valid_i & q_ready_i & k_accept_i`.
  - Increments pend[rd] if k_writeback_i[0] and rd != 0.
  - Increments pend[rdd] if k_writeback_i[1].
  - k_writeback_i[1] with odd rd: rdd increment still done, err_o set.
- Retire event: `ret = p_valid_i & p_ready_i`.
  - Decrements pend[p_rd_i] if p_rd_i != 0.
  - If p_dual_writeback_i, also decrements pend[{p_rd_i[4:1], 1'b1}].
- tot: + number of increments - number of decrements, same cycle.
- Simultaneous iss and ret on the same register: net change computed (+1, -1 → unchanged). No ordering dependence.
- Underflow: decrement of a zero counter (or tot) leaves it at 0 and sets err_o.
- Overflow: never occurs. Outputs block issue first; if an increment would exceed a limit anyway, saturate and set err_o.
- err_o: sticky until reset.
- Outputs are combinational from registered state plus instr_data_i. No same-cycle bypass: a retire frees the register one cycle later, and an issue is visible in the next cycle.
  - rs_valid_o[i] = (rs_i == 0) | (pend[rs_i] == 0).
  - rd_clean_o[j]:
    - requires target pend == 0 if InOrderWb = 0, else pend < MaxPerReg;
    - always requires tot + 2 <= MaxTotal (conservative, covers dual writeback);
    - rd == 0 counts as clean for bit0, subject to the tot rule.
  - busy_o = (tot != 0); full_o = (tot == MaxTotal).
- Combinational path requirement: no path from q_ready_i, k_accept_i or p_* to any output (avoids loop through the adapter's q_ready).
- Assertions:
  - iss with a writeback bit set while the matching rd_clean_o is low → error.
  - tot equals the sum of pend.

Test Plan:
- Reset, then instr rd = x5 (rs1 = x5) issued with k_writeback = 01 → next cycle pend[5] = 1, busy_o = 1, rs_valid_o[0] = 0 for any instr with rs1 = 5, rd_clean_o[0] = 0 (InOrderWb = 0). Then p_valid/p_ready with p_rd = 5 → one cycle later pend[5] = 0, rs_valid_o = 111, busy_o = 0.
- Issue rd = x0 with writeback 01 → no counter change, tot = 0, err_o = 0.
- Dual: issue rd = x6 with writeback 11 → pend[6] = pend[7] = 1, tot = 2. Retire p_rd = 6, dual = 1 → both clear, tot = 0.
- Same cycle: issue rd = x9 while retiring x9 (pend[9] = 1) → pend[9] stays 1, tot unchanged.
- MaxTotal = 8:
  - issue 7 single writebacks to x1..x7 → tot = 7, full_o = 0, rd_clean_o = 00 (7 + 2 > 8);
  - retire one → rd_clean_o returns to 11 for a clean rd.
- Retire p_rd = 12 with pend[12] = 0 → pend stays 0, err_o = 1 and stays set. Async reset asserted mid-sequence → all outputs return to reset values immediately.
